// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch sequencer.
// Reads one 32-bit instruction word from instruction memory at the
// current PC and hands it to decode. While decode holds the word, the
// unit waits, and it redirects the PC when a branch is presented.
// The external PC register is driven through load (pc_ld/pc_in) and
// post-increment (pc_post_count/pc_count) controls.
//
// Optional feature: define FETCH_TIMEOUT_EN to add a 4-bit memory-wait
// counter. After 16 consecutive stalled fetch cycles the unit enters a
// sticky ERROR state that is reported on fetch_err. Only reset clears
// ERROR. In the default build a fetch waits for memory indefinitely.
module fetch_unit (
  input  logic        clk,
  input  logic        rst,            // asynchronous, active low
  input  logic [31:0] pc_value,
  output logic        pc_ld,
  output logic [31:0] pc_in,
  output logic        pc_post_count,
  output logic [7:0]  pc_count,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        ir_valid,
  output logic [31:0] ir_data,
  input  logic        ir_ready,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic        branch_ack
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic        fetch_err
`endif
);

`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [1:0] {ST_FETCH, ST_HOLD, ST_BRANCH, ST_ERROR} state_e;
`else
  typedef enum logic [1:0] {ST_FETCH, ST_HOLD, ST_BRANCH} state_e;
`endif

  state_e      r_state;
  logic        r_ir_valid;
  logic [31:0] r_ir_data;
  logic        r_pc_ld;
  logic [31:0] r_pc_in;
  logic        r_branch_ack;
  logic        w_fetching;

`ifdef FETCH_TIMEOUT_EN
  logic [3:0]  r_wait_cnt;
  logic        r_fetch_err;
`endif

  // NOTE: rst is folded into the combinational fetch qualifier. This forces
  // mem_rd and pc_post_count low while reset is held. The reset state is
  // FETCH, so without this term those outputs would still respond to
  // mem_ready during reset.
  assign w_fetching    = (r_state == ST_FETCH) && rst;

  assign mem_rd        = w_fetching;
  assign mem_addr      = pc_value;
  assign pc_post_count = w_fetching && mem_ready && !branch_valid;
  assign pc_count      = 8'd1;
  assign pc_ld         = r_pc_ld;
  assign pc_in         = r_pc_in;
  assign branch_ack    = r_branch_ack;
  assign ir_valid      = r_ir_valid;
  assign ir_data       = r_ir_data;
`ifdef FETCH_TIMEOUT_EN
  assign fetch_err     = r_fetch_err;
`endif

  // Main sequencer: state transitions and the registered handshake outputs.
  // NOTE: every sequential assignment is non-blocking. All flops then sample
  // the values from before the edge, whatever order the statements are in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_FETCH;
      r_ir_valid   <= 1'b0;
      r_ir_data    <= 32'd0;
      r_pc_ld      <= 1'b0;
      r_pc_in      <= 32'd0;
      r_branch_ack <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      r_fetch_err  <= 1'b0;
`endif
    end else begin
      r_pc_ld      <= 1'b0;
      r_branch_ack <= 1'b0;
      case (r_state)
        ST_FETCH: begin
          if (mem_ready) begin
            if (branch_valid) begin
              // Returned word lies on the wrong path: drop it and redirect.
              r_state      <= ST_BRANCH;
              r_pc_ld      <= 1'b1;
              r_branch_ack <= 1'b1;
              r_pc_in      <= branch_target;
            end else begin
              r_state      <= ST_HOLD;
              r_ir_valid   <= 1'b1;
              r_ir_data    <= mem_rdata;
            end
          end
`ifdef FETCH_TIMEOUT_EN
          else if (r_wait_cnt == 4'hF) begin
            r_state     <= ST_ERROR;
            r_fetch_err <= 1'b1;
          end
`endif
        end
        ST_HOLD: begin
          if (branch_valid) begin
            // The held word is consumed or dropped on this same edge.
            r_state      <= ST_BRANCH;
            r_ir_valid   <= 1'b0;
            r_pc_ld      <= 1'b1;
            r_branch_ack <= 1'b1;
            r_pc_in      <= branch_target;
          end else if (ir_ready) begin
            r_state      <= ST_FETCH;
            r_ir_valid   <= 1'b0;
          end
        end
        ST_BRANCH: begin
          r_state <= ST_FETCH;
        end
`ifdef FETCH_TIMEOUT_EN
        ST_ERROR: begin
          r_state <= ST_ERROR;
        end
`endif
        default: begin
          r_state <= ST_FETCH;
        end
      endcase
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Wait counter: cleared outside FETCH (so it is zero on entry), and
  // incremented on each FETCH cycle where memory has not answered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait_cnt <= 4'd0;
    end else if (r_state != ST_FETCH) begin
      r_wait_cnt <= 4'd0;
    end else if (!mem_ready) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. The bench provides the external PC
// register, a procedural instruction memory and a branch source. A queue
// and address-stream reference model check the randomized traffic.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_value;
  logic        pc_ld;
  logic [31:0] pc_in;
  logic        pc_post_count;
  logic [7:0]  pc_count;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        ir_valid;
  logic [31:0] ir_data;
  logic        ir_ready;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        branch_ack;
`ifdef FETCH_TIMEOUT_EN
  logic        fetch_err;
`endif

  int tests = 0;
  int fails = 0;

  // External PC register, with a bench-side preset used only during reset.
  logic        pc_set;
  logic [31:0] pc_set_val;
  logic [31:0] pc_reg;

  always @(posedge clk) begin
    if (pc_set)             pc_reg <= pc_set_val;
    else if (pc_ld)         pc_reg <= pc_in;
    else if (pc_post_count) pc_reg <= pc_reg + 32'(pc_count);
  end
  assign pc_value = pc_reg;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .pc_value     (pc_value),
    .pc_ld        (pc_ld),
    .pc_in        (pc_in),
    .pc_post_count(pc_post_count),
    .pc_count     (pc_count),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .ir_valid     (ir_valid),
    .ir_data      (ir_data),
    .ir_ready     (ir_ready),
    .branch_valid (branch_valid),
    .branch_target(branch_target),
    .branch_ack   (branch_ack)
`ifdef FETCH_TIMEOUT_EN
    ,
    .fetch_err    (fetch_err)
`endif
  );

  // Contents of the instruction memory used in randomized traffic.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  // Hold reset for a cycle while presetting the PC, then release it at a
  // falling edge. The caller continues in the first post-reset cycle.
  task automatic apply_reset(input logic [31:0] pc0);
    rst = 1'b0;
    mem_ready = 1'b0; ir_ready = 1'b0; branch_valid = 1'b0;
    branch_target = 32'd0; mem_rdata = 32'd0;
    pc_set = 1'b1; pc_set_val = pc0;
    @(posedge clk); #1 pc_set = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset(32'h40);
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D; ir_ready = 1'b0;
    @(negedge clk);                       // HOLD with 0xCAFEF00D
    branch_valid = 1'b1; branch_target = 32'h999; mem_ready = 1'b0;
    @(negedge clk);                       // BRANCH
    #1;
    tests++; if (branch_ack !== 1'b1) begin fails++; $display("FAIL rst_pre_ack: got %b want 1", branch_ack); end
    branch_valid = 1'b0; mem_ready = 1'b1;
    rst = 1'b0;
    #1;
    tests++; if (ir_valid !== 1'b0) begin fails++; $display("FAIL rst_ir_valid: got %b want 0", ir_valid); end
    tests++; if (ir_data !== 32'd0) begin fails++; $display("FAIL rst_ir_data: got %h want 0", ir_data); end
    tests++; if (branch_ack !== 1'b0) begin fails++; $display("FAIL rst_branch_ack: got %b want 0", branch_ack); end
    tests++; if (pc_ld !== 1'b0) begin fails++; $display("FAIL rst_pc_ld: got %b want 0", pc_ld); end
    tests++; if (pc_post_count !== 1'b0) begin fails++; $display("FAIL rst_pc_post_count: got %b want 0", pc_post_count); end
`ifdef FETCH_TIMEOUT_EN
    tests++; if (fetch_err !== 1'b0) begin fails++; $display("FAIL rst_fetch_err: got %b want 0", fetch_err); end
`endif
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++; if (mem_rd !== 1'b1) begin fails++; $display("FAIL rst_release_mem_rd: got %b want 1", mem_rd); end
    tests++; if (mem_addr !== 32'h41) begin fails++; $display("FAIL rst_release_addr: got %h want 41", mem_addr); end
  endtask

  task automatic test_basic_fetch();
    apply_reset(32'h100);
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF; ir_ready = 1'b1;
    #1;
    tests++; if (mem_addr !== 32'h100) begin fails++; $display("FAIL basic_addr: got %h want 100", mem_addr); end
    tests++; if (pc_post_count !== 1'b1) begin fails++; $display("FAIL basic_post_count: got %b want 1", pc_post_count); end
    tests++; if (pc_count !== 8'd1) begin fails++; $display("FAIL basic_pc_count: got %0d want 1", pc_count); end
    tests++; if (pc_ld !== 1'b0) begin fails++; $display("FAIL basic_pc_ld: got %b want 0", pc_ld); end
    @(negedge clk);
    mem_rdata = 32'h1234_5678;
    #1;
    tests++; if (ir_valid !== 1'b1) begin fails++; $display("FAIL basic_ir_valid: got %b want 1", ir_valid); end
    tests++; if (ir_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL basic_ir_data: got %h want deadbeef", ir_data); end
    tests++; if (pc_value !== 32'h101) begin fails++; $display("FAIL basic_pc_inc: got %h want 101", pc_value); end
    tests++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL basic_hold_mem_rd: got %b want 0", mem_rd); end
    tests++; if (pc_post_count !== 1'b0) begin fails++; $display("FAIL basic_hold_post: got %b want 0", pc_post_count); end
    @(negedge clk);
    #1;
    tests++; if (mem_rd !== 1'b1 || mem_addr !== 32'h101) begin fails++; $display("FAIL basic_refetch: got rd=%b addr=%h want rd=1 addr=101", mem_rd, mem_addr); end
    tests++; if (ir_valid !== 1'b0) begin fails++; $display("FAIL basic_refetch_ir_valid: got %b want 0", ir_valid); end
  endtask

  task automatic test_wait_states();
    int pulses = 0;
    logic [31:0] w = 32'd0;
    apply_reset(32'h300);
    ir_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      w = $urandom;
      mem_rdata = w;
      #1;
      tests++; if (mem_rd !== 1'b1 || mem_addr !== 32'h300) begin fails++; $display("FAIL wait_rd_addr[%0d]: got rd=%b addr=%h want rd=1 addr=300", i, mem_rd, mem_addr); end
      tests++; if (pc_post_count !== (i == 3)) begin fails++; $display("FAIL wait_post[%0d]: got %b want %b", i, pc_post_count, (i == 3)); end
      if (pc_post_count === 1'b1) pulses++;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    #1;
    tests++; if (pulses != 1) begin fails++; $display("FAIL wait_pulses: got %0d want 1", pulses); end
    tests++; if (ir_valid !== 1'b1 || ir_data !== w) begin fails++; $display("FAIL wait_ir: got v=%b d=%h want v=1 d=%h", ir_valid, ir_data, w); end
    tests++; if (pc_value !== 32'h301) begin fails++; $display("FAIL wait_pc: got %h want 301", pc_value); end
  endtask

  task automatic test_hold_stall();
    logic [31:0] w;
    apply_reset(32'h20);
    w = $urandom;
    mem_ready = 1'b1; mem_rdata = w; ir_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      mem_rdata = $urandom; mem_ready = 1'(i % 2); ir_ready = 1'b0;
      #1;
      tests++; if (ir_valid !== 1'b1 || ir_data !== w) begin fails++; $display("FAIL stall_ir[%0d]: got v=%b d=%h want v=1 d=%h", i, ir_valid, ir_data, w); end
      tests++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL stall_mem_rd[%0d]: got %b want 0", i, mem_rd); end
      @(negedge clk);
    end
    ir_ready = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    #1;
    tests++; if (mem_rd !== 1'b1 || mem_addr !== 32'h21) begin fails++; $display("FAIL stall_release: got rd=%b addr=%h want rd=1 addr=21", mem_rd, mem_addr); end
  endtask

  task automatic test_branch_in_fetch();
    apply_reset(32'h80);
    branch_valid = 1'b1; branch_target = 32'h200; mem_ready = 1'b0; ir_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests++; if (mem_rd !== 1'b1 || mem_addr !== 32'h80) begin fails++; $display("FAIL bf_wait_rd[%0d]: got rd=%b addr=%h want rd=1 addr=80", i, mem_rd, mem_addr); end
      tests++; if (branch_ack !== 1'b0 || pc_ld !== 1'b0) begin fails++; $display("FAIL bf_wait_ack[%0d]: got ack=%b ld=%b want 0 0", i, branch_ack, pc_ld); end
      @(negedge clk);
    end
    mem_ready = 1'b1; mem_rdata = $urandom;
    #1;
    tests++; if (pc_post_count !== 1'b0) begin fails++; $display("FAIL bf_no_post: got %b want 0", pc_post_count); end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    tests++; if (pc_ld !== 1'b1 || pc_in !== 32'h200) begin fails++; $display("FAIL bf_load: got ld=%b in=%h want ld=1 in=200", pc_ld, pc_in); end
    tests++; if (branch_ack !== 1'b1) begin fails++; $display("FAIL bf_ack: got %b want 1", branch_ack); end
    tests++; if (ir_valid !== 1'b0 || pc_post_count !== 1'b0 || mem_rd !== 1'b0) begin fails++; $display("FAIL bf_quiet: got v=%b post=%b rd=%b want 0 0 0", ir_valid, pc_post_count, mem_rd); end
    tests++; if (pc_value !== 32'h80) begin fails++; $display("FAIL bf_pc_unchanged: got %h want 80", pc_value); end
    @(negedge clk);
    branch_valid = 1'b0;
    #1;
    tests++; if (mem_rd !== 1'b1 || mem_addr !== 32'h200) begin fails++; $display("FAIL bf_redirect: got rd=%b addr=%h want rd=1 addr=200", mem_rd, mem_addr); end
    tests++; if (branch_ack !== 1'b0 || pc_ld !== 1'b0) begin fails++; $display("FAIL bf_ack_drop: got ack=%b ld=%b want 0 0", branch_ack, pc_ld); end
  endtask

  task automatic test_branch_in_hold();
    apply_reset(32'h10);
    mem_ready = 1'b1; mem_rdata = 32'h0BAD_CAFE; ir_ready = 1'b0;
    @(negedge clk);
    branch_valid = 1'b1; branch_target = 32'h400; mem_ready = 1'b0;
    #1;
    tests++; if (ir_valid !== 1'b1) begin fails++; $display("FAIL bh_hold: got %b want 1", ir_valid); end
    @(negedge clk);
    #1;
    tests++; if (branch_ack !== 1'b1 || pc_ld !== 1'b1 || pc_in !== 32'h400) begin fails++; $display("FAIL bh_branch: got ack=%b ld=%b in=%h want 1 1 400", branch_ack, pc_ld, pc_in); end
    tests++; if (ir_valid !== 1'b0) begin fails++; $display("FAIL bh_ir_valid: got %b want 0", ir_valid); end
    @(negedge clk);
    branch_valid = 1'b0;
    #1;
    tests++; if (mem_rd !== 1'b1 || mem_addr !== 32'h400) begin fails++; $display("FAIL bh_redirect: got rd=%b addr=%h want rd=1 addr=400", mem_rd, mem_addr); end
  endtask

  task automatic test_reset_in_hold();
    logic [31:0] w;
    apply_reset(32'h50);
    mem_ready = 1'b1; mem_rdata = 32'h7777_0001; ir_ready = 1'b0;
    @(negedge clk);
    #1;
    tests++; if (ir_valid !== 1'b1) begin fails++; $display("FAIL rh_hold: got %b want 1", ir_valid); end
    #1 rst = 1'b0;
    #1;
    tests++; if (ir_valid !== 1'b0) begin fails++; $display("FAIL rh_ir_valid: got %b want 0", ir_valid); end
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b0;
    #1;
    tests++; if (mem_rd !== 1'b1 || mem_addr !== 32'h51) begin fails++; $display("FAIL rh_release: got rd=%b addr=%h want rd=1 addr=51", mem_rd, mem_addr); end
    // Abandon a read that is still waiting, then complete it after reset.
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    w = $urandom;
    mem_ready = 1'b1; mem_rdata = w; ir_ready = 1'b1;
    #1;
    tests++; if (mem_rd !== 1'b1 || pc_post_count !== 1'b1) begin fails++; $display("FAIL rh_midread: got rd=%b post=%b want 1 1", mem_rd, pc_post_count); end
    @(negedge clk);
    #1;
    tests++; if (ir_valid !== 1'b1 || ir_data !== w) begin fails++; $display("FAIL rh_midread_ir: got v=%b d=%h want v=1 d=%h", ir_valid, ir_data, w); end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset(32'h60);
    // Counter restarts on each new FETCH: 10 waits, a word, then 15 waits.
    for (int i = 0; i < 10; i++) @(negedge clk);
    mem_ready = 1'b1; ir_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 15; i++) @(negedge clk);
    #1;
    tests++; if (fetch_err !== 1'b0 || mem_rd !== 1'b1) begin fails++; $display("FAIL to_restart: got err=%b rd=%b want 0 1", fetch_err, mem_rd); end
    apply_reset(32'h60);
    for (int i = 0; i < 16; i++) begin
      #1;
      tests++; if (fetch_err !== 1'b0 || mem_rd !== 1'b1) begin fails++; $display("FAIL to_wait[%0d]: got err=%b rd=%b want 0 1", i, fetch_err, mem_rd); end
      @(negedge clk);
    end
    #1;
    tests++; if (fetch_err !== 1'b1) begin fails++; $display("FAIL to_err: got %b want 1", fetch_err); end
    tests++; if (mem_rd !== 1'b0 || ir_valid !== 1'b0) begin fails++; $display("FAIL to_quiet: got rd=%b v=%b want 0 0", mem_rd, ir_valid); end
    branch_valid = 1'b1; branch_target = 32'h123; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      tests++; if (fetch_err !== 1'b1 || branch_ack !== 1'b0 || pc_ld !== 1'b0 || mem_rd !== 1'b0) begin fails++; $display("FAIL to_sticky[%0d]: got err=%b ack=%b ld=%b rd=%b want 1 0 0 0", i, fetch_err, branch_ack, pc_ld, mem_rd); end
    end
    apply_reset(32'h60);
    #1;
    tests++; if (fetch_err !== 1'b0) begin fails++; $display("FAIL to_cleared: got %b want 0", fetch_err); end
  endtask
`else
  task automatic test_no_timeout();
    apply_reset(32'h60);
    for (int i = 0; i < 40; i++) @(negedge clk);
    #1;
    tests++; if (mem_rd !== 1'b1 || mem_addr !== 32'h60 || ir_valid !== 1'b0) begin fails++; $display("FAIL nt_wait: got rd=%b addr=%h v=%b want 1 60 0", mem_rd, mem_addr, ir_valid); end
  endtask
`endif

  // Randomized traffic against a model of the spec's transaction rules:
  // address stream, queue of delivered words, and one-cycle responses.
  task automatic test_random();
    logic [31:0] q[$];
    logic [31:0] exp_addr, br_tgt, p_tgt;
    logic        br_pend, p_mem_rd, p_ir_valid, p_ack, comp, hold;
    int          waitc;
    exp_addr = $urandom & 32'h0000_FFFF;
    apply_reset(exp_addr);
    br_pend = 1'b0; br_tgt = 32'd0; p_tgt = 32'd0;
    p_mem_rd = 1'b1; p_ir_valid = 1'b0; p_ack = 1'b0; waitc = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      mem_ready = (waitc >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
      mem_rdata = word_of(mem_addr);
      ir_ready  = ($urandom_range(0, 2) != 0);
      if (!br_pend && $urandom_range(0, 9) == 0) begin
        br_pend = 1'b1; br_tgt = $urandom;
      end
      branch_valid = br_pend; branch_target = br_tgt;
      #1;
      tests++; if (mem_rd !== p_mem_rd) begin fails++; $display("FAIL rnd_mem_rd@%0d: got %b want %b", cyc, mem_rd, p_mem_rd); end
      tests++; if (ir_valid !== p_ir_valid) begin fails++; $display("FAIL rnd_ir_valid@%0d: got %b want %b", cyc, ir_valid, p_ir_valid); end
      tests++; if (branch_ack !== p_ack || pc_ld !== p_ack) begin fails++; $display("FAIL rnd_ack@%0d: got ack=%b ld=%b want %b", cyc, branch_ack, pc_ld, p_ack); end
      if (p_ack) begin
        tests++; if (pc_in !== p_tgt) begin fails++; $display("FAIL rnd_pc_in@%0d: got %h want %h", cyc, pc_in, p_tgt); end
      end
      tests++; if (pc_ld === 1'b1 && pc_post_count === 1'b1) begin fails++; $display("FAIL rnd_ld_and_post@%0d: got both 1 want exclusive", cyc); end
      tests++; if (pc_post_count !== (p_mem_rd && mem_ready && !branch_valid)) begin fails++; $display("FAIL rnd_post@%0d: got %b want %b", cyc, pc_post_count, (p_mem_rd && mem_ready && !branch_valid)); end
      if (p_mem_rd) begin
        tests++; if (mem_addr !== exp_addr) begin fails++; $display("FAIL rnd_addr@%0d: got %h want %h", cyc, mem_addr, exp_addr); end
      end
      if (p_ir_valid) begin
        tests++;
        if (q.size() == 0) begin fails++; $display("FAIL rnd_ir_empty@%0d: got ir_valid with no word outstanding", cyc); end
        else if (ir_data !== q[0]) begin fails++; $display("FAIL rnd_ir_data@%0d: got %h want %h", cyc, ir_data, q[0]); end
      end
      comp = p_mem_rd && mem_ready;
      hold = p_ir_valid;
      if (comp && !branch_valid) begin
        q.push_back(word_of(exp_addr));
        exp_addr = exp_addr + 32'd1;
      end
      if (hold && (ir_ready || branch_valid) && q.size() > 0) void'(q.pop_front());
      if (p_ack) begin
        exp_addr = p_tgt;
        br_pend  = 1'b0;
      end
      waitc = (p_mem_rd && !mem_ready) ? waitc + 1 : 0;
      p_mem_rd   = (p_mem_rd && !mem_ready) || (hold && ir_ready && !branch_valid) || p_ack;
      p_ir_valid = (comp && !branch_valid) || (hold && !ir_ready && !branch_valid);
      p_ack      = (comp || hold) && branch_valid;
      if (p_ack) p_tgt = branch_target;
      @(negedge clk);
    end
    branch_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    pc_set = 1'b0; pc_set_val = 32'd0;
    mem_ready = 1'b0; mem_rdata = 32'd0; ir_ready = 1'b0;
    branch_valid = 1'b0; branch_target = 32'd0;
    test_reset();
    test_basic_fetch();
    test_wait_states();
    test_hold_stall();
    test_branch_in_fetch();
    test_branch_in_hold();
    test_reset_in_hold();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
